// File: rtl/rr_arb_mux.sv
// Round-robin arbitrating N:1 merge with val/rdy handshakes and one registered
// output stage. Each forwarded message carries the index of its source port.
module rr_arb_mux #(
  parameter  int p_nbits   = 8,
  parameter  int p_ninputs = 4,
  localparam int c_sw      = $clog2(p_ninputs)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p_ninputs*p_nbits-1:0]  recv_msg,
  input  logic [p_ninputs-1:0]          recv_val,
  output logic [p_ninputs-1:0]          recv_rdy,
  output logic [p_nbits-1:0]            send_msg,
  output logic [c_sw-1:0]               send_src,
  output logic                          send_val,
  input  logic                          send_rdy
);

  localparam logic [c_sw-1:0] c_last = c_sw'(p_ninputs - 1);
  localparam logic [c_sw:0]   c_n    = (c_sw + 1)'(p_ninputs);

  logic [c_sw-1:0]    ptr;
  logic [c_sw-1:0]    ptr_nxt;
  logic [c_sw-1:0]    grant;
  logic               grant_any;
  logic [c_sw:0]      scan_idx;
  logic [p_nbits-1:0] grant_msg;
  logic               free;
  logic               xfer;

  // Output register can take a new message when empty or draining this cycle.
  // Reset is folded in so nothing is offered upstream while it is asserted.
  assign free = !send_val || send_rdy;
  assign xfer = reset && free && grant_any;

  // Scan requesters starting at ptr, wrapping at p_ninputs (not at 2**c_sw).
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < p_ninputs; k++) begin
      scan_idx = {1'b0, ptr} + (c_sw + 1)'(k);
      if (scan_idx >= c_n) scan_idx = scan_idx - c_n;
      if (!grant_any && recv_val[scan_idx[c_sw-1:0]]) begin
        grant     = scan_idx[c_sw-1:0];
        grant_any = 1'b1;
      end
    end
  end

  // Select the granted port's message; port 0 sits in the MSBs.
  always_comb begin
    grant_msg = '0;
    for (int i = 0; i < p_ninputs; i++) begin
      if (grant == c_sw'(i)) grant_msg = recv_msg[(p_ninputs-1-i)*p_nbits +: p_nbits];
    end
  end

  // One-hot ready to the winner only; independent of message contents.
  always_comb begin
    recv_rdy = '0;
    if (xfer) recv_rdy[grant] = 1'b1;
  end

  assign ptr_nxt = (grant == c_last) ? '0 : grant + c_sw'(1);

  // Output register and priority pointer; ptr only moves on a transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      send_msg <= '0;
      send_src <= '0;
      send_val <= 1'b0;
      ptr      <= '0;
    end else if (xfer) begin
      send_msg <= grant_msg;
      send_src <= grant;
      send_val <= 1'b1;
      ptr      <= ptr_nxt;
    end else if (send_val && send_rdy) begin
      send_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus randomized traffic checked
// against a behavioural model (rotating-priority scan with modulo arithmetic).
module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] msg4;
  logic [3:0]  val4;
  logic [3:0]  rdy4;
  logic [7:0]  smsg4;
  logic [1:0]  ssrc4;
  logic        sval4;
  logic        srdy4;

  logic [23:0] msg3;
  logic [2:0]  val3;
  logic [2:0]  rdy3;
  logic [7:0]  smsg3;
  logic [1:0]  ssrc3;
  logic        sval3;
  logic        srdy3;

  int total = 0;
  int bad   = 0;

  // behavioural model state for the 4-port instance
  int         m_ptr;
  logic       m_val;
  logic [7:0] m_msg;
  int         m_src;

  always #5 clk = ~clk;

  rr_arb_mux #(.p_nbits(8), .p_ninputs(4)) dut4 (
    .clk(clk), .reset(rst_n), .recv_msg(msg4), .recv_val(val4), .recv_rdy(rdy4),
    .send_msg(smsg4), .send_src(ssrc4), .send_val(sval4), .send_rdy(srdy4)
  );

  rr_arb_mux #(.p_nbits(8), .p_ninputs(3)) dut3 (
    .clk(clk), .reset(rst_n), .recv_msg(msg3), .recv_val(val3), .recv_rdy(rdy3),
    .send_msg(smsg3), .send_src(ssrc3), .send_val(sval3), .send_rdy(srdy3)
  );

  // first requester found scanning from ptr with wrap; -1 when nothing is granted
  function automatic int exp_grant(input int ptr, input logic [3:0] v, input int n, input logic busy);
    if (busy) return -1;
    for (int k = 0; k < n; k++) if (v[(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  function automatic logic [3:0] oh4(input int g);
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  // advance one clock edge and update the model from the inputs present at that edge
  task automatic tick4();
    int g;
    g = exp_grant(m_ptr, val4, 4, m_val && !srdy4);
    @(posedge clk); #1;
    if (g >= 0) begin
      m_msg = msg4[(3-g)*8 +: 8];
      m_src = g;
      m_val = 1'b1;
      m_ptr = (g + 1) % 4;
    end else if (m_val && srdy4) begin
      m_val = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    val4 = '0; val3 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_val = 1'b0; m_msg = '0; m_src = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    val4 = 4'b0000; val3 = '0; msg4 = '0; msg3 = '0; srdy4 = 1'b1; srdy3 = 1'b1;
    #3;
    total++; if (sval4 !== 1'b0) begin bad++; $display("FAIL reset_val got=%b want=0", sval4); end
    total++; if (smsg4 !== 8'h00) begin bad++; $display("FAIL reset_msg got=%h want=00", smsg4); end
    total++; if (ssrc4 !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d want=0", ssrc4); end
    total++; if (rdy4 !== 4'b0000) begin bad++; $display("FAIL reset_rdy got=%b want=0000", rdy4); end
    val4 = 4'b1111;
    #1;
    total++; if (rdy4 !== 4'b0000) begin bad++; $display("FAIL reset_rdy_valid got=%b want=0000", rdy4); end
    do_reset();
  endtask

  task automatic test_single();
    val4 = 4'b0100; msg4 = {8'h00, 8'h00, 8'hA5, 8'h00}; srdy4 = 1'b1;
    #1;
    total++; if (rdy4 !== 4'b0100) begin bad++; $display("FAIL single_rdy got=%b want=0100", rdy4); end
    tick4();
    total++; if (smsg4 !== 8'hA5) begin bad++; $display("FAIL single_msg got=%h want=a5", smsg4); end
    total++; if (ssrc4 !== 2'd2) begin bad++; $display("FAIL single_src got=%0d want=2", ssrc4); end
    total++; if (sval4 !== 1'b1) begin bad++; $display("FAIL single_val got=%b want=1", sval4); end
  endtask

  task automatic test_round_robin();
    do_reset();
    val4 = 4'b1111; msg4 = {8'h10, 8'h11, 8'h12, 8'h13}; srdy4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++; if (rdy4 !== oh4(k % 4)) begin bad++; $display("FAIL rr_rdy[%0d] got=%b want=%b", k, rdy4, oh4(k % 4)); end
      tick4();
      total++; if (ssrc4 !== 2'(k % 4)) begin bad++; $display("FAIL rr_src[%0d] got=%0d want=%0d", k, ssrc4, k % 4); end
      total++; if (sval4 !== 1'b1) begin bad++; $display("FAIL rr_val[%0d] got=%b want=1", k, sval4); end
      total++; if (smsg4 !== 8'(8'h10 + k % 4)) begin bad++; $display("FAIL rr_msg[%0d] got=%h want=%h", k, smsg4, 8'(8'h10 + k % 4)); end
    end
  endtask

  task automatic test_skip_wrap();
    @(negedge clk);
    val4 = 4'b0110; msg4 = {8'h40, 8'h41, 8'h42, 8'h43};
    #1;
    total++; if (rdy4 !== 4'b0010) begin bad++; $display("FAIL wrap_rdy1 got=%b want=0010", rdy4); end
    tick4();
    total++; if (ssrc4 !== 2'd1) begin bad++; $display("FAIL wrap_src1 got=%0d want=1", ssrc4); end
    @(negedge clk); #1;
    total++; if (rdy4 !== 4'b0100) begin bad++; $display("FAIL wrap_rdy2 got=%b want=0100", rdy4); end
    tick4();
    total++; if (ssrc4 !== 2'd2 || smsg4 !== 8'h42) begin bad++; $display("FAIL wrap_out2 got=%0d/%h want=2/42", ssrc4, smsg4); end
  endtask

  task automatic test_backpressure();
    do_reset();
    val4 = 4'b0010; msg4 = {8'h77, 8'h3C, 8'h00, 8'h00}; srdy4 = 1'b1;
    tick4();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      srdy4 = 1'b0; val4 = 4'b0101; msg4 = {8'h77, 8'h00, 8'h99, 8'h00};
      #1;
      total++; if (rdy4 !== 4'b0000) begin bad++; $display("FAIL bp_rdy[%0d] got=%b want=0000", k, rdy4); end
      tick4();
      total++; if (smsg4 !== 8'h3C || ssrc4 !== 2'd1 || sval4 !== 1'b1)
        begin bad++; $display("FAIL bp_hold[%0d] got=%h/%0d/%b want=3c/1/1", k, smsg4, ssrc4, sval4); end
    end
    @(negedge clk);
    srdy4 = 1'b1;
    #1;
    total++; if (rdy4 !== 4'b0100) begin bad++; $display("FAIL bp_release_rdy got=%b want=0100", rdy4); end
    tick4();
    total++; if (ssrc4 !== 2'd2 || smsg4 !== 8'h99) begin bad++; $display("FAIL bp_release_out got=%0d/%h want=2/99", ssrc4, smsg4); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    srdy4 = 1'b0; val4 = 4'b1001; msg4 = {8'hE0, 8'h00, 8'h00, 8'hE3};
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (sval4 !== 1'b0) begin bad++; $display("FAIL midrst_val got=%b want=0", sval4); end
    total++; if (smsg4 !== 8'h00 || ssrc4 !== 2'd0) begin bad++; $display("FAIL midrst_regs got=%h/%0d want=00/0", smsg4, ssrc4); end
    total++; if (rdy4 !== 4'b0000) begin bad++; $display("FAIL midrst_rdy got=%b want=0000", rdy4); end
    @(negedge clk);
    rst_n = 1'b1; srdy4 = 1'b1;
    m_ptr = 0; m_val = 1'b0; m_msg = '0; m_src = 0;
    #1;
    total++; if (rdy4 !== 4'b0001) begin bad++; $display("FAIL midrst_rdy_after got=%b want=0001", rdy4); end
    tick4();
    total++; if (ssrc4 !== 2'd0 || smsg4 !== 8'hE0) begin bad++; $display("FAIL midrst_out got=%0d/%h want=0/e0", ssrc4, smsg4); end
  endtask

  task automatic test_random();
    int g;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      val4  = 4'($urandom_range(0, 15));
      msg4  = $urandom;
      srdy4 = ($urandom_range(0, 3) != 0);
      #1;
      g = exp_grant(m_ptr, val4, 4, m_val && !srdy4);
      total++; if (rdy4 !== oh4(g)) begin bad++; $display("FAIL rand_rdy[%0d] got=%b want=%b", k, rdy4, oh4(g)); end
      tick4();
      total++; if (sval4 !== m_val) begin bad++; $display("FAIL rand_val[%0d] got=%b want=%b", k, sval4, m_val); end
      if (m_val) begin
        total++; if (smsg4 !== m_msg || ssrc4 !== 2'(m_src))
          begin bad++; $display("FAIL rand_out[%0d] got=%h/%0d want=%h/%0d", k, smsg4, ssrc4, m_msg, m_src); end
      end
    end
  endtask

  task automatic test_nonpow2();
    do_reset();
    val3 = 3'b111; msg3 = {8'h20, 8'h21, 8'h22}; srdy3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++; if (rdy3 !== 3'(1 << (k % 3))) begin bad++; $display("FAIL np2_rdy[%0d] got=%b want=%b", k, rdy3, 3'(1 << (k % 3))); end
      @(posedge clk); #1;
      total++; if (ssrc3 !== 2'(k % 3)) begin bad++; $display("FAIL np2_src[%0d] got=%0d want=%0d", k, ssrc3, k % 3); end
      total++; if (ssrc3 === 2'd3) begin bad++; $display("FAIL np2_src_range[%0d] got=3 want<3", k); end
      total++; if (sval3 !== 1'b1 || smsg3 !== 8'(8'h20 + k % 3))
        begin bad++; $display("FAIL np2_out[%0d] got=%b/%h want=1/%h", k, sval3, smsg3, 8'(8'h20 + k % 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_nonpow2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
